sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Parametrised sprite renderer for the VGA path; successor to the fixed full-screen 32x32 ROM stretcher.
- Places one square sprite at a runtime (x,y) position with power-of-two scaling, 4-way rotation and transparency keying.
- Emits the sprite ROM address plus a pipelined, pixel-aligned colour index and hit flag for the downstream compositor/palette.
- Position, direction and enable are shadow-latched once per frame, which prevents tearing.

Parameters:
- SIZE, 32, sprite edge in texels (square sprite).
- SCALE_SHIFT, 0, on-screen magnification = 2^SCALE_SHIFT.
- ADDR_W, 10, ROM address width; must be at least log2(SIZE*SIZE).
- IDX_W, 8, palette index width.
- TRANSPARENT_IDX, 0, palette index treated as see-through.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_sync  in  1  one-cycle pulse at frame start; loads the shadow registers.
- sprite_x  in  10  top-left column, staged.
- sprite_y  in  10  top-left row, staged.
- dir  in  2  0 = up, 1 = 90 deg CW, 2 = 180 deg, 3 = 270 deg; staged.
- sprite_en  in  1  staged enable.
- flash  in  1  flash request; used only with FLASH_EN.
- rom_address  out  ADDR_W  to the external synchronous ROM (1-cycle read latency).
- rom_q  in  IDX_W  ROM data, valid one cycle after the address.
- color_idx  out  IDX_W  palette index, registered.
- hit  out  1  1 = opaque sprite pixel at the aligned position, registered.

Behaviour:
- Reset clears shadow x, y, dir and en to 0, all pipeline stages to 0, and color_idx, hit and rom_address to 0. Reset has priority over frame_sync. Reset mid-frame means no hits until the next frame_sync loads en=1.
- Shadow load: on the frame_sync cycle, register sprite_x, sprite_y, dir and sprite_en. At all other times the staged inputs are ignored.
- Stage 0 (cycle n, combinational from DrawX/DrawY and the shadow registers):
  - inbox = en & (DrawX >= sx) & (DrawX < sx + (SIZE<<SCALE_SHIFT)) & the same test for Y.
  - Compare at 11 bits so a sprite overlapping column 639 or row 479 clips instead of wrapping.
  - lx = (DrawX - sx) >> SCALE_SHIFT; ly = (DrawY - sy) >> SCALE_SHIFT.
  - Texel select, with S = SIZE:
    - dir 0: col = lx, row = ly.
    - dir 1: col = ly, row = S-1-lx.
    - dir 2: col = S-1-lx, row = S-1-ly.
    - dir 3: col = S-1-ly, row = lx.
  - rom_address = row*SIZE + col, truncated to ADDR_W. Registered at the edge ending cycle n.
  - Outside the box, rom_address holds its previous value (don't-care for the ROM, but deterministic).
- Stage 1 (cycle n+1): inbox & blank are delayed one stage to align with the ROM read.
- Stage 2 (cycle n+2):
  - color_idx <= rom_q.
  - hit <= delayed(inbox & blank) & (rom_q != TRANSPARENT_IDX).
  - Total latency from DrawX/DrawY to hit/color_idx is exactly 2 cycles at all times.
- blank low forces hit=0 two cycles later; color_idx still updates.
- en=0 forces hit=0 for the whole frame.
- frame_sync asserted while a sprite pixel is in flight: the pipeline completes with the old values; the new shadow values apply from the next stage-0 cycle.

Optional Feature:
- Macro: SPRITE_BLITTER_FLASH_EN.
- When defined:
  - A 4-bit frame counter increments on each frame_sync and clears on Reset.
  - flash is latched with the other shadow inputs.
  - While shadow flash=1 and counter bit 2 = 1, hit is forced to 0. This gives a blink with a period of 8 frames.
- When undefined: no counter, the flash port is ignored, and hit is unaffected.

Test Plan:
- Reset, then frame_sync with x=100, y=50, dir=0, en=1; sweep DrawX=100, DrawY=50 -> rom_address=0 after one edge; rom_q=5 -> hit=1, color_idx=5 at n+2.
- dir=1, SIZE=32, pixel at (lx=0, ly=0) -> rom_address=31*32+0=992; dir=2 at the same pixel -> 1023; dir=3 -> 31.
- SCALE_SHIFT=1, x=0: DrawX=0..3 on row 0 -> addresses 0, 0, 1, 1; DrawX=64 -> inbox=0, hit=0.
- x=630, DrawX=639 -> hit follows the ROM data; DrawX=0 on the same row -> hit=0 (no wrap).
- rom_q=TRANSPARENT_IDX inside the box -> hit=0; blank=0 inside the box -> hit=0 two cycles later.
- FLASH_EN: flash=1, 16 frame_sync pulses -> hit suppressed in frames 4-7 and 12-15 (counter 4-7 and 12-15), present otherwise; Reset asserted mid-frame -> hit=0 until frame_sync reloads en=1.

Source files
------------

// File: rtl/sprite_blitter.sv
// sprite_blitter: places one square SIZE x SIZE sprite at a per-frame (x,y)
// with power-of-two magnification, 4-way rotation and transparency keying.
// Emits the ROM address and a pixel-aligned colour index / hit flag
// (2-cycle latency from DrawX/DrawY). The ROM address register doubles as
// the ROM's input register, so rom_q is valid in the cycle after the pixel.
// Optional blink feature: define SPRITE_BLITTER_FLASH_EN.
module sprite_blitter #(
    parameter int                SIZE            = 32,
    parameter int                SCALE_SHIFT     = 0,
    parameter int                ADDR_W          = 10,
    parameter int                IDX_W           = 8,
    parameter logic [IDX_W-1:0]  TRANSPARENT_IDX = '0
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_sync,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [1:0]        dir,
    input  logic              sprite_en,
    input  logic              flash,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  color_idx,
    output logic              hit
);

    // On-screen edge length; 11 bits so boxes near the right/bottom clip.
    localparam logic [10:0]       SPAN   = 11'(SIZE << SCALE_SHIFT);
    localparam logic [9:0]        S_M1   = 10'(SIZE - 1);
    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE);

    // Shadow registers (loaded once per frame)
    logic [9:0]        sx_q, sx_d;
    logic [9:0]        sy_q, sy_d;
    logic [1:0]        dir_q, dir_d;
    logic              en_q, en_d;
    // Pipeline
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              vis_q, vis_d;
    logic [IDX_W-1:0]  color_idx_q, color_idx_d;
    logic              hit_q, hit_d;

    // Stage-0 combinational signals
    logic              in_x, in_y, inbox, blink_off;
    logic [10:0]       x_end, y_end;
    logic [9:0]        dx, dy, lx, ly, col, row;
    logic [ADDR_W-1:0] texel_addr;

`ifdef SPRITE_BLITTER_FLASH_EN
    logic              flash_q, flash_d;
    logic [3:0]        frame_cnt_q, frame_cnt_d;
    assign blink_off = flash_q & frame_cnt_q[2];
`else
    logic              flash_unused;
    assign flash_unused = flash;
    assign blink_off    = 1'b0;
`endif

    // Stage 0: box test and rotated texel address for the current pixel
    always_comb begin
        x_end = {1'b0, sx_q} + SPAN;
        y_end = {1'b0, sy_q} + SPAN;
        in_x  = ({1'b0, DrawX} >= {1'b0, sx_q}) && ({1'b0, DrawX} < x_end);
        in_y  = ({1'b0, DrawY} >= {1'b0, sy_q}) && ({1'b0, DrawY} < y_end);
        inbox = en_q & in_x & in_y;
        dx    = DrawX - sx_q;
        dy    = DrawY - sy_q;
        lx    = dx >> SCALE_SHIFT;
        ly    = dy >> SCALE_SHIFT;
        col   = lx;
        row   = ly;
        case (dir_q)
            2'd1: begin col = ly;        row = S_M1 - lx; end
            2'd2: begin col = S_M1 - lx; row = S_M1 - ly; end
            2'd3: begin col = S_M1 - ly; row = lx;        end
            default: begin col = lx;     row = ly;        end
        endcase
        texel_addr = ADDR_W'(row) * SIZE_A + ADDR_W'(col);
    end

    // Next-state: shadow load on frame_sync, address hold outside the box,
    // visibility delayed to meet rom_q, then keyed against transparency
    always_comb begin
        sx_d          = sx_q;
        sy_d          = sy_q;
        dir_d         = dir_q;
        en_d          = en_q;
        rom_address_d = rom_address_q;
`ifdef SPRITE_BLITTER_FLASH_EN
        flash_d       = flash_q;
        frame_cnt_d   = frame_cnt_q;
`endif
        if (frame_sync) begin
            sx_d  = sprite_x;
            sy_d  = sprite_y;
            dir_d = dir;
            en_d  = sprite_en;
`ifdef SPRITE_BLITTER_FLASH_EN
            flash_d     = flash;
            frame_cnt_d = frame_cnt_q + 4'd1;
`endif
        end
        if (inbox) begin
            rom_address_d = texel_addr;
        end
        vis_d       = inbox & blank & ~blink_off;
        color_idx_d = rom_q;
        hit_d       = vis_q & (rom_q != TRANSPARENT_IDX);
    end

    // State registers with synchronous reset taking priority over frame_sync
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            sx_q          <= '0;
            sy_q          <= '0;
            dir_q         <= '0;
            en_q          <= 1'b0;
            rom_address_q <= '0;
            vis_q         <= 1'b0;
            color_idx_q   <= '0;
            hit_q         <= 1'b0;
`ifdef SPRITE_BLITTER_FLASH_EN
            flash_q       <= 1'b0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            dir_q         <= dir_d;
            en_q          <= en_d;
            rom_address_q <= rom_address_d;
            vis_q         <= vis_d;
            color_idx_q   <= color_idx_d;
            hit_q         <= hit_d;
`ifdef SPRITE_BLITTER_FLASH_EN
            flash_q       <= flash_d;
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign rom_address = rom_address_q;
    assign color_idx   = color_idx_q;
    assign hit         = hit_q;

endmodule
